// File: rtl/nios_design_interval_timer_if.sv
// -----------------------------------------------------------------------------
// nios_design_interval_timer_if
//
// Avalon-MM slave bundle for the interval timer, plus the interrupt line and
// a debug view of the run/stop state machine.
//
// Transfer rules:
//   - A write happens at a rising clk edge where chipselect=1 and write_n=0.
//     There is no waitrequest, so every write is accepted at the edge where
//     it is presented.
//   - readdata is registered every clock from whatever address is present at
//     that edge, whether or not chipselect is asserted. The value of the
//     register addressed at edge E is visible on readdata after edge E.
//
// Signals:
//   address     [2:0]   register select                     (master -> slave)
//   chipselect          slave select                        (master -> slave)
//   write_n             active-low write strobe             (master -> slave)
//   writedata   [15:0]  write data                          (master -> slave)
//   readdata    [15:0]  registered read data                (slave -> master)
//   irq                 level interrupt, TO & ITO           (slave -> master)
//   dbg_state           current run/stop state, 1 = RUN     (slave -> master)
// -----------------------------------------------------------------------------
interface nios_design_interval_timer_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;
    logic        dbg_state;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq,
        input  dbg_state
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq,
        output dbg_state
    );
endinterface

// File: rtl/nios_design_interval_timer.sv
// -----------------------------------------------------------------------------
// nios_design_interval_timer
//
// Software-controlled interval timer on a 16-bit Avalon-MM slave. A down
// counter of COUNTER_WIDTH bits reloads from a writable period register when
// it expires, setting the sticky timeout flag TO. The timer runs one-shot or
// continuously, can be started/stopped by software, and can snapshot the live
// counter for reading.
//
// Parameters:
//   COUNTER_WIDTH  counter/period width, 17..32
//   RESET_PERIOD   period and counter value at reset (truncated to width)
//   RUN_AT_RESET   1 = running in continuous mode straight out of reset
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      Avalon-MM slave bundle (address, chipselect, write_n, writedata,
//            readdata, irq, dbg_state)
//
// Register map:
//   0 status   R {14'b0, RUN, TO}      W any value clears TO
//   1 control  R {14'b0, CONT, ITO}    W bit0 ITO, bit1 CONT, bit2 START,
//                                        bit3 STOP (START/STOP are strobes)
//   2 periodl  period[15:0]
//   3 periodh  period[W-1:16], zero-extended on read
//   4 snapl    snapshot[15:0]          W any value captures the counter
//   5 snaph    snapshot[W-1:16]        W any value captures the counter
//   6,7        read 0, writes ignored
// -----------------------------------------------------------------------------
module nios_design_interval_timer #(
    parameter int          COUNTER_WIDTH = 32,
    parameter logic [31:0] RESET_PERIOD  = 32'd49999,
    parameter bit          RUN_AT_RESET  = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    nios_design_interval_timer_if.slave   bus
);

    localparam int CW = COUNTER_WIDTH;
    // Width of the upper period/snapshot half (1..16 bits).
    localparam int HW = CW - 16;

    localparam logic [CW-1:0] RST_PERIOD = RESET_PERIOD[CW-1:0];
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERIODL = 3'd2;
    localparam logic [2:0] ADDR_PERIODH = 3'd3;
    localparam logic [2:0] ADDR_SNAPL   = 3'd4;
    localparam logic [2:0] ADDR_SNAPH   = 3'd5;

    // The RUN bit is the state of a two-state machine.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_t;

    run_state_t      r_state;
    run_state_t      w_state_next;

    logic [CW-1:0]   r_counter;
    logic [CW-1:0]   r_period;
    logic [CW-1:0]   r_snap;
    logic            r_to;
    logic            r_ito;
    logic            r_cont;
    logic [15:0]     r_readdata;

    logic [CW-1:0]   w_period_new;
    logic [15:0]     w_rd_mux;
    logic            w_wr;
    logic            w_wr_status;
    logic            w_wr_ctrl;
    logic            w_wr_perl;
    logic            w_wr_perh;
    logic            w_wr_period;
    logic            w_wr_snap;
    logic            w_run;
    logic            w_timeout;
    logic            w_unused_wdata;

    // -------------------------------------------------------------------------
    // Write decode
    // -------------------------------------------------------------------------
    assign w_wr        = bus.chipselect && !bus.write_n;
    assign w_wr_status = w_wr && (bus.address == ADDR_STATUS);
    assign w_wr_ctrl   = w_wr && (bus.address == ADDR_CONTROL);
    assign w_wr_perl   = w_wr && (bus.address == ADDR_PERIODL);
    assign w_wr_perh   = w_wr && (bus.address == ADDR_PERIODH);
    assign w_wr_period = w_wr_perl || w_wr_perh;
    assign w_wr_snap   = w_wr && ((bus.address == ADDR_SNAPL) ||
                                  (bus.address == ADDR_SNAPH));

    // Upper writedata bits beyond the periodh width are deliberately dropped.
    assign w_unused_wdata = ^bus.writedata;

    assign w_run = (r_state == ST_RUN);

    // A period write outranks expiry: the counter reloads from the new value
    // and no timeout is flagged at that edge.
    assign w_timeout = w_run && (r_counter == '0) && !w_wr_period;

    // Period value after this edge, with the addressed half replaced. The
    // counter loads this merged value, so a half write takes effect at once.
    always_comb begin
        w_period_new = r_period;
        if (w_wr_perl) begin
            w_period_new[15:0] = bus.writedata;
        end
        if (w_wr_perh) begin
            w_period_new[CW-1:16] = bus.writedata[HW-1:0];
        end
    end

    // -------------------------------------------------------------------------
    // Run/stop state machine
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if (RUN_AT_RESET) begin
                r_state <= ST_RUN;
            end else begin
                r_state <= ST_IDLE;
            end
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_wr_period) begin
            w_state_next = ST_IDLE;
        end else if (w_timeout) begin
            // One-shot stops at expiry, continuous keeps running. The CONT
            // value used is the one held before this edge.
            if (r_cont) begin
                w_state_next = ST_RUN;
            end else begin
                w_state_next = ST_IDLE;
            end
        end
        // Control strobes are applied last. STOP dominates START; START
        // only matters when the timer was stopped before this edge.
        if (w_wr_ctrl) begin
            if (bus.writedata[3]) begin
                w_state_next = ST_IDLE;
            end else if (bus.writedata[2] && !w_run) begin
                w_state_next = ST_RUN;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Counter, period, flags and snapshot
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_counter <= RST_PERIOD;
            r_period  <= RST_PERIOD;
            r_snap    <= '0;
            r_to      <= 1'b0;
            r_ito     <= 1'b0;
            r_cont    <= RUN_AT_RESET;
        end else begin
            r_period <= w_period_new;

            // Uses the RUN value held before this edge, so a START write
            // first decrements one edge later and a STOP write still sees
            // its own edge counted.
            if (w_wr_period) begin
                r_counter <= w_period_new;
            end else if (w_timeout) begin
                r_counter <= r_period;
            end else if (w_run) begin
                r_counter <= r_counter - CNT_ONE;
            end

            // Set beats clear so a timeout coinciding with a status write
            // is not lost.
            if (w_timeout) begin
                r_to <= 1'b1;
            end else if (w_wr_status) begin
                r_to <= 1'b0;
            end

            if (w_wr_ctrl) begin
                r_ito  <= bus.writedata[0];
                r_cont <= bus.writedata[1];
            end

            // Captures the pre-edge counter value.
            if (w_wr_snap) begin
                r_snap <= r_counter;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read path: registered every clock from the current address
    // -------------------------------------------------------------------------
    always_comb begin
        w_rd_mux = '0;
        case (bus.address)
            ADDR_STATUS:  w_rd_mux = {14'b0, w_run, r_to};
            ADDR_CONTROL: w_rd_mux = {14'b0, r_cont, r_ito};
            ADDR_PERIODL: w_rd_mux = r_period[15:0];
            ADDR_PERIODH: w_rd_mux[HW-1:0] = r_period[CW-1:16];
            ADDR_SNAPL:   w_rd_mux = r_snap[15:0];
            ADDR_SNAPH:   w_rd_mux[HW-1:0] = r_snap[CW-1:16];
            default:      w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign bus.readdata  = r_readdata;
    assign bus.irq       = r_to & r_ito;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_nios_design_interval_timer.sv
// -----------------------------------------------------------------------------
// tb_nios_design_interval_timer
//
// Two timer instances share one set of bus inputs: dut0 with default
// parameters, dut1 with COUNTER_WIDTH=20. `sel` picks which instance's
// outputs are compared. Inputs change on the falling edge; outputs are
// sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_nios_design_interval_timer;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- bus
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    int          sel = 0;

    nios_design_interval_timer_if bus0 ();
    nios_design_interval_timer_if bus1 ();

    assign bus0.address    = address;
    assign bus0.chipselect = chipselect;
    assign bus0.write_n    = write_n;
    assign bus0.writedata  = writedata;
    assign bus1.address    = address;
    assign bus1.chipselect = chipselect;
    assign bus1.write_n    = write_n;
    assign bus1.writedata  = writedata;

    nios_design_interval_timer dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    nios_design_interval_timer #(
        .COUNTER_WIDTH (20)
    ) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    logic [15:0] rd_mux;
    logic        irq_mux;
    logic        dbg_mux;
    assign rd_mux  = (sel == 1) ? bus1.readdata  : bus0.readdata;
    assign irq_mux = (sel == 1) ? bus1.irq       : bus0.irq;
    assign dbg_mux = (sel == 1) ? bus1.dbg_state : bus0.dbg_state;

    // ---------------------------------------------------------------- scoreboard
    logic [15:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, got, exp);
        end
    endtask

    task automatic chk_irq(input string name, input logic exp);
        check(name, {15'b0, irq_mux}, {15'b0, exp});
    endtask

    task automatic chk_run(input string name, input logic exp);
        check(name, {15'b0, dbg_mux}, {15'b0, exp});
    endtask

    // ---------------------------------------------------------------- drivers
    task automatic drive(input logic [2:0] a, input logic w, input logic [15:0] d);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        write_n    = !w;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        drive(a, 1'b1, d);
    endtask

    task automatic idle();
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string name, input logic [2:0] a, input logic [15:0] exp);
        logic [15:0] e;
        exp_q.push_back(exp);
        drive(a, 1'b0, 16'h0000);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard queue empty", name);
        end else begin
            e = exp_q.pop_front();
            check(name, rd_mux, e);
        end
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        logic [2:0]  addr;
        logic        wr;
        logic [15:0] wdata;
        logic        chk_rd;
        logic [15:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[10];

    // ---------------------------------------------------------------- watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- test
    initial begin
        // Reset-state register checks for dut0 (default parameters).
        vecs[0] = '{3'd0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0};
        vecs[1] = '{3'd1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0};
        vecs[2] = '{3'd2, 1'b0, 16'h0000, 1'b1, 16'hC34F, 1'b0};
        vecs[3] = '{3'd3, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0};
        vecs[4] = '{3'd4, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0};
        vecs[5] = '{3'd4, 1'b0, 16'h0000, 1'b1, 16'hC34F, 1'b0};
        vecs[6] = '{3'd5, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0};
        vecs[7] = '{3'd6, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b0};
        vecs[8] = '{3'd6, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0};
        vecs[9] = '{3'd7, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0};

        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 16'h0000;
        reset_n    = 1'b0;

        #12;
        check("reset_readdata", rd_mux, 16'h0000);
        chk_irq("reset_irq", 1'b0);
        chk_run("reset_run", 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].chk_rd) begin
                exp_q.push_back(vecs[i].exp_rd);
            end
            drive(vecs[i].addr, vecs[i].wr, vecs[i].wdata);
            chk_irq($sformatf("vec%0d_irq", i), vecs[i].exp_irq);
            if (vecs[i].chk_rd) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL vec%0d: scoreboard queue empty", i);
                end else begin
                    check($sformatf("vec%0d_rd", i), rd_mux, exp_q.pop_front());
                end
            end
        end

        // ---- continuous mode, period 4: events 5 cycles apart
        wr(3'd2, 16'h0004);
        wr(3'd3, 16'h0000);
        wr(3'd1, 16'h0007);                    // edge N: ITO|CONT|START
        chk_run("a_run_after_start", 1'b1);
        for (int i = 1; i <= 4; i++) begin
            idle();
            chk_irq($sformatf("a_pre_%0d", i), 1'b0);
        end
        idle();                                // N+5
        chk_irq("a_first_event", 1'b1);
        wr(3'd0, 16'h0000);                    // N+6 clears TO
        chk_irq("a_cleared", 1'b0);
        for (int i = 7; i <= 9; i++) begin
            idle();
            chk_irq($sformatf("a_gap_%0d", i), 1'b0);
        end
        idle();                                // N+10
        chk_irq("a_second_event", 1'b1);
        for (int i = 0; i < 4; i++) begin
            idle();                            // N+11..N+14
        end
        wr(3'd0, 16'h0000);                    // N+15: clear collides with event
        chk_irq("a_same_cycle_irq", 1'b1);
        rd("a_same_cycle_status", 3'd0, 16'h0003);

        // ---- STOP holds the counter; START resumes from the held value
        wr(3'd1, 16'h0008);                    // counter 3 -> 2 at this edge, then held
        chk_run("c_stopped", 1'b0);
        wr(3'd0, 16'h0000);
        rd("c_status_stopped", 3'd0, 16'h0000);
        wr(3'd4, 16'h0000);
        rd("c_snap_first", 3'd4, 16'h0002);
        for (int i = 0; i < 10; i++) begin
            idle();
        end
        wr(3'd5, 16'h0000);
        rd("c_snap_second_l", 3'd4, 16'h0002);
        rd("c_snap_second_h", 3'd5, 16'h0000);
        wr(3'd1, 16'h0005);                    // edge T: ITO|START, one-shot
        chk_run("c_resumed", 1'b1);
        idle();
        idle();                                // T+2: counter reaches 0
        chk_irq("c_before_event", 1'b0);
        idle();                                // T+3
        chk_irq("c_event", 1'b1);
        rd("c_status_oneshot", 3'd0, 16'h0001);

        // ---- one-shot, period 3: exactly one event
        wr(3'd2, 16'h0003);
        wr(3'd0, 16'h0000);
        wr(3'd1, 16'h0005);                    // edge N
        for (int i = 1; i <= 3; i++) begin
            idle();
            chk_irq($sformatf("b_pre_%0d", i), 1'b0);
        end
        idle();                                // N+4
        chk_irq("b_event", 1'b1);
        for (int i = 0; i < 6; i++) begin
            idle();
        end
        chk_irq("b_sticky", 1'b1);
        rd("b_status", 3'd0, 16'h0001);
        wr(3'd4, 16'h0000);
        rd("b_snap", 3'd4, 16'h0003);
        wr(3'd0, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            idle();
        end
        chk_irq("b_no_second_event", 1'b0);
        chk_run("b_stopped", 1'b0);

        // ---- COUNTER_WIDTH=20 instance: periodh masking, period write stops
        sel = 1;
        wr(3'd1, 16'h0004);                    // START, ITO=0, CONT=0
        idle();
        chk_run("d_running", 1'b1);
        wr(3'd3, 16'hFFFF);                    // period = 0xF0003, counter loaded, stopped
        chk_run("d_stopped_by_period", 1'b0);
        rd("d_periodh", 3'd3, 16'h000F);
        wr(3'd5, 16'h0000);
        rd("d_snaph", 3'd5, 16'h000F);
        rd("d_snapl", 3'd4, 16'h0003);
        for (int i = 0; i < 5; i++) begin
            idle();
        end
        wr(3'd4, 16'h0000);
        rd("d_snapl_held", 3'd4, 16'h0003);
        wr(3'd0, 16'h0000);
        rd("d_status", 3'd0, 16'h0000);
        chk_irq("d_irq", 1'b0);

        // ---- asynchronous reset mid-operation (dut0 running)
        sel = 0;
        wr(3'd1, 16'h0007);
        idle();
        chk_run("r_running_before_reset", 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_run("r_async_run_cleared", 1'b0);
        check("r_async_readdata", rd_mux, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        rd("r_periodl_after_reset", 3'd2, 16'hC34F);
        rd("r_control_after_reset", 3'd1, 16'h0000);

        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
